fp_mult_seq_param: RTL
======================

// Module: fp_mult_seq_param
// PURPOSE
//  Parametrised sequential floating-point multiplier: a shift-add mantissa core with
//  normalise, round-to-nearest-even and IEEE-754 special-case handling.
//  Supports any EXP_W/MAN_W format and valid/ready handshakes on both sides.
//  Sits between the input and output wrappers, in place of the fixed single-precision
//  datapath/controller pair. Emits exception flags alongside each result.
// PARAMETERS
//  EXP_W  8   exponent field width (>=3)
//  MAN_W  23  stored fraction width, hidden bit excluded (>=2)
//  Derived: W = 1+EXP_W+MAN_W; BIAS = 2**(EXP_W-1)-1
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can accept operands
//  a, b       in   W      operands {sign, exp, frac}
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  W      product
//  flags      out  4      {invalid, overflow, underflow, inexact}, valid with result
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, result=0, flags=0. FSM goes to IDLE; counter and all
//   datapath registers clear. Reset mid-operation aborts the operation with no output.
//  FSM states: IDLE -> MULT -> NORM -> PACK -> HOLD -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid, latch a and b, clear the partial product and counter, go to MULT.
//  MULT: runs MAN_W+1 cycles, one multiplier bit per cycle (LSB first). Each cycle:
//   - P += A_lsb ? {1,fracB} : 0;
//   - {P,A} shifts right one bit.
//   - Full 2*(MAN_W+1)-bit product is retained.
//  NORM (1 cycle):
//   - If product bit[2*MAN_W+1] is set, shift right 1 and add 1 to the exponent.
//   - Form guard bit and sticky bit (OR of all remaining low bits).
//  Exponent arithmetic: signed EXP_W+2 bits, e = ea + eb - BIAS + norm.
//  PACK (1 cycle):
//   - Round to nearest, ties to even. A mantissa carry-out adds 1 to the exponent.
//   - Apply specials in priority order:
//     1. NaN operand, or inf*0: result = {0, all-ones exp, 1, zeros}; invalid=1.
//     2. Inf operand: signed inf.
//     3. Zero or subnormal operand (flushed to zero): signed zero, no flags.
//     4. e >= 2**EXP_W-1 after rounding: signed inf; overflow=1, inexact=1.
//     5. e <= 0: signed zero (flush to zero); underflow=1, inexact=1.
//     6. Otherwise: normal result; inexact = guard|sticky.
//   - Result sign is always sa^sb, including for zero and inf results.
//   - Register result and flags; set out_valid; go to HOLD.
//  Latency: out_valid rises exactly MAN_W+3 cycles after the accept edge, for every
//   operand class, specials included.
//  HOLD:
//   - out_valid=1; result and flags held stable while out_ready=0.
//   - On out_ready: out_valid clears at the next edge and FSM returns to IDLE.
//   - in_ready stays 0 outside IDLE, so no new accept in the HOLD-exit cycle;
//     minimum issue interval is MAN_W+5 cycles.
//  in_valid and operand changes outside IDLE are ignored.
//  result and flags keep their last value after out_valid drops.
// TESTING (defaults EXP_W=8, MAN_W=23)
//  1. 0x3FC00000 * 0x40000000 -> 0x40400000, flags 0, out_valid exactly 26 cycles
//     after accept; also 0xC0000000 * 0x40400000 -> 0xC0C00000.
//  2. 0x3F800001 * 0x3F800001 -> 0x3F800002, inexact=1 (RNE, sticky only);
//     0x3FFFFFFF * 0x3FFFFFFF -> 0x407FFFFE, inexact=1.
//  3. Specials:
//     - 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1;
//     - 0xFF800000 * 0x40000000 -> 0xFF800000, flags 0;
//     - 0x00400000 (subnormal) * 0x3F800000 -> 0x00000000, flags 0.
//  4. Range:
//     - 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow=1, inexact=1;
//     - 0x00800000 * 0x00800000 -> 0x00000000, underflow=1, inexact=1.
//  5. Handshake:
//     - Hold out_ready=0 for 10 cycles: result and flags stable, in_ready=0;
//     - in_valid pulses during MULT are ignored;
//     - back-to-back stream of 100 random normal pairs matches a reference model.
//  6. Assert rst during MULT: out_valid stays 0, in_ready=1 next cycle;
//     next operation is correct. Rerun tests 1-4 with EXP_W=5, MAN_W=10:
//     0x3E00 * 0x4000 -> 0x4200.

Source files
------------

// File: rtl/fp_mult_seq_param.sv
// Sequential floating-point multiplier for any EXP_W/MAN_W format: shift-add mantissa
// core, normalise, round-to-nearest-even, special-case handling and flush-to-zero.
module fp_mult_seq_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * (MAN_W + 1);
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MAN_W + 1);
    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {IDLE, MULT, NORM, PACK, HOLD} state_t;
    state_t state_reg, state_next;

    logic [W-1:0]           opa_reg, opb_reg;
    logic [MAN_W:0]         mpl_reg;
    logic [MAN_W+1:0]       acc_reg;
    logic [CW-1:0]          cnt_reg;
    logic [MAN_W:0]         mant_reg;
    logic                   guard_reg, sticky_reg;
    logic signed [EW-1:0]   exp_reg;
    logic [W-1:0]           result_reg;
    logic [3:0]             flags_reg;

    // Operand fields and classification
    logic                   sa, sb, rs;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sa = opa_reg[W-1];
    assign sb = opb_reg[W-1];
    assign rs = sa ^ sb;
    assign ea = opa_reg[W-2 -: EXP_W];
    assign eb = opb_reg[W-2 -: EXP_W];
    assign fa = opa_reg[MAN_W-1:0];
    assign fb = opb_reg[MAN_W-1:0];
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);

    // One shift-add step: multiplier bits leave mpl_reg LSB-first while product
    // bits shift in at its top, so {acc_reg, mpl_reg} ends up holding the product.
    logic [MAN_W+1:0] addend, sum;
    assign addend = mpl_reg[0] ? {2'b01, fb} : '0;
    assign sum    = acc_reg + addend;

    logic [PW-1:0]        product, norm_shift;
    logic signed [EW-1:0] e_norm;
    assign product    = {acc_reg[MAN_W:0], mpl_reg};
    assign norm_shift = product[PW-1] ? product : (product << 1);
    assign e_norm     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS
                        + $signed({{(EW-1){1'b0}}, product[PW-1]});

    logic                 round_up;
    logic [MAN_W+1:0]     mant_rnd;
    logic signed [EW-1:0] e_rnd;
    logic [MAN_W-1:0]     frac_rnd;
    assign round_up = guard_reg & (sticky_reg | mant_reg[0]);
    assign mant_rnd = {1'b0, mant_reg} + {{(MAN_W+1){1'b0}}, round_up};
    assign e_rnd    = exp_reg + $signed({{(EW-1){1'b0}}, mant_rnd[MAN_W+1]});
    assign frac_rnd = mant_rnd[MAN_W+1] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];

    logic [W-1:0] pack_result;
    logic [3:0]   pack_flags;
    always_comb begin
        pack_result = {rs, e_rnd[EXP_W-1:0], frac_rnd};
        pack_flags  = {3'b000, guard_reg | sticky_reg};
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
            pack_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            pack_flags  = 4'b1000;
        end else if (a_inf | b_inf) begin
            pack_result = {rs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_flags  = 4'b0000;
        end else if (a_zero | b_zero) begin
            pack_result = {rs, {(W-1){1'b0}}};
            pack_flags  = 4'b0000;
        end else if (e_rnd >= EXP_MAX) begin
            pack_result = {rs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_flags  = 4'b0101;
        end else if (e_rnd[EW-1] | ~(|e_rnd)) begin
            pack_result = {rs, {(W-1){1'b0}}};
            pack_flags  = 4'b0011;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = MULT;
            end
            MULT:    if (cnt_reg == CW'(MAN_W)) state_next = NORM;
            NORM:    state_next = PACK;
            PACK:    state_next = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_reg    <= '0;
            opb_reg    <= '0;
            mpl_reg    <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            mant_reg   <= '0;
            guard_reg  <= 1'b0;
            sticky_reg <= 1'b0;
            exp_reg    <= '0;
            result_reg <= '0;
            flags_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        opa_reg <= a;
                        opb_reg <= b;
                        mpl_reg <= {1'b1, a[MAN_W-1:0]};
                        acc_reg <= '0;
                        cnt_reg <= '0;
                    end
                end
                MULT: begin
                    acc_reg <= {1'b0, sum[MAN_W+1:1]};
                    mpl_reg <= {sum[0], mpl_reg[MAN_W:1]};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                NORM: begin
                    mant_reg   <= norm_shift[PW-1 -: MAN_W+1];
                    guard_reg  <= norm_shift[MAN_W];
                    sticky_reg <= |norm_shift[MAN_W-1:0];
                    exp_reg    <= e_norm;
                end
                PACK: begin
                    result_reg <= pack_result;
                    flags_reg  <= pack_flags;
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;
    assign flags  = flags_reg;

endmodule
